// File: rtl/line_mac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_mac_pkg : shared types and width helpers for the spike-gated line MAC  |
// | Revision     : 2.0                                                          |
// +----------------------------------------------------------------------------+
package line_mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FIRST = 2'd1,
      ST_ACCUM = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam int c_FIFO_DEPTH = 2;

   // Lane t of a packed bus of W-bit lanes starts at bit t*W.
   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

   function automatic int cnt_w(input int line_len);
      return (line_len > 1) ? $clog2(line_len) : 1;
   endfunction

   function automatic int lcnt_w(input int num_lines);
      return $clog2(num_lines + 1);
   endfunction

endpackage : line_mac_pkg
`default_nettype wire

// File: rtl/line_mac_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_mac_ram : simple dual-port line buffer with registered read port       |
// | Revision     : 2.0                                                          |
// +----------------------------------------------------------------------------+
module line_mac_ram
   import line_mac_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int WIDTH = 48,
   parameter int AW    = cnt_w(64)
)(
   input  logic             s_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // No reset on the array or read register so the tools can map this to block/LUT RAM.
   always_ff @(posedge s_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule : line_mac_ram
`default_nettype wire

// File: rtl/line_mac_acc_pe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | line_mac_acc_pe : spike-gated attention x value line accumulator            |
// | Optional: define LINE_MAC_SAT_EN for clamping adds and a sticky o_sat flag  |
// | Revision        : 2.0                                                       |
// +----------------------------------------------------------------------------+
module line_mac_acc_pe
   import line_mac_pkg::*;
#(
   parameter int T_STEPS   = 4,
   parameter int IN_W      = 5,
   parameter int ACC_W     = 12,
   parameter int LINE_LEN  = 64,
   parameter int NUM_LINES = 64
)(
   input  logic                     s_clk,
   input  logic                     s_rst,
   input  logic                     i_clear,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [T_STEPS-1:0]       i_spikes,
   input  logic [T_STEPS*IN_W-1:0]  i_attn,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [T_STEPS*ACC_W-1:0] o_data,
   output logic                     o_last,
   output logic                     o_busy
`ifdef LINE_MAC_SAT_EN
   ,
   output logic                     o_sat
`endif
);

   localparam int c_CNT_W  = cnt_w(LINE_LEN);
   localparam int c_LCNT_W = lcnt_w(NUM_LINES);
   localparam int c_DW     = T_STEPS * ACC_W;
   localparam logic [c_CNT_W-1:0]  c_LAST_ELEM = c_CNT_W'(LINE_LEN - 1);
   localparam logic [c_LCNT_W-1:0] c_LAST_LINE = c_LCNT_W'(NUM_LINES - 1);

   state_t               r_state;
   logic                 r_ready;
   logic [c_CNT_W-1:0]   r_elem;
   logic [c_LCNT_W-1:0]  r_line;
   logic [c_CNT_W-1:0]   r_rd_ptr;
   logic                 r_rd_done;

   logic                 r_s0_v;
   logic                 r_s0_first;
   logic [c_CNT_W-1:0]   r_s0_addr;
   logic [c_DW-1:0]      r_s0_prod;
   logic                 r_s1_v;
   logic [c_CNT_W-1:0]   r_s1_addr;
   logic [c_DW-1:0]      r_s1_data;

   logic                 r_rd_v;
   logic                 r_rd_last;
   logic [c_DW-1:0]      r_fifo_data [c_FIFO_DEPTH];
   logic [1:0]           r_fifo_last;
   logic                 r_head;
   logic [1:0]           r_cnt;

   logic [c_DW-1:0]      w_prod;
   logic [c_DW-1:0]      w_sum;
   logic [c_DW-1:0]      w_ram_rdata;
   logic [c_CNT_W-1:0]   w_ram_raddr;
   logic                 w_ram_re;
   logic                 w_ram_we;
   logic                 w_accept;
   logic                 w_issue;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_wr_idx;
   logic [1:0]           w_cnt_next;
   logic                 w_drain_done;

   assign w_accept     = i_valid && r_ready && (r_state != ST_DRAIN) && !i_clear;
   assign w_push       = r_rd_v;
   assign w_pop        = o_valid && i_ready;
   assign w_cnt_next   = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
   assign w_wr_idx     = r_head ^ r_cnt[0];
   assign w_drain_done = (r_state == ST_DRAIN) && w_pop && r_fifo_last[r_head];

   // Drain reads start only once the accumulate pipeline has retired its writes,
   // and are issued only when the skid FIFO is guaranteed a free slot.
   assign w_issue = (r_state == ST_DRAIN) && !r_s0_v && !r_s1_v && !r_rd_done
                    && !w_cnt_next[1] && !i_clear;

   assign w_ram_re    = w_issue || (w_accept && (r_state == ST_ACCUM));
   assign w_ram_raddr = (r_state == ST_DRAIN) ? r_rd_ptr : r_elem;
   assign w_ram_we    = r_s1_v && !i_clear;

   line_mac_ram #(
      .DEPTH (LINE_LEN),
      .WIDTH (c_DW),
      .AW    (c_CNT_W)
   ) u_ram (
      .s_clk   (s_clk),
      .i_we    (w_ram_we),
      .i_waddr (r_s1_addr),
      .i_wdata (r_s1_data),
      .i_re    (w_ram_re),
      .i_raddr (w_ram_raddr),
      .o_rdata (w_ram_rdata)
   );

`ifdef LINE_MAC_SAT_EN
   logic [T_STEPS-1:0] w_clamp;
`endif

   for (genvar t = 0; t < T_STEPS; t++) begin : g_lane
      localparam int c_IN_LO  = lane_lo(t, IN_W);
      localparam int c_ACC_LO = lane_lo(t, ACC_W);
      logic [ACC_W-1:0] w_old;
`ifdef LINE_MAC_SAT_EN
      logic [ACC_W:0]   w_full;
`endif

      assign w_prod[c_ACC_LO +: ACC_W] = i_spikes[t]
         ? {{(ACC_W-IN_W){1'b0}}, i_attn[c_IN_LO +: IN_W]} : '0;
      // Line 0 overwrites the buffer, so stale RAM contents never reach the sum.
      assign w_old = r_s0_first ? '0 : w_ram_rdata[c_ACC_LO +: ACC_W];

`ifdef LINE_MAC_SAT_EN
      assign w_full     = {1'b0, w_old} + {1'b0, r_s0_prod[c_ACC_LO +: ACC_W]};
      assign w_clamp[t] = w_full[ACC_W];
      assign w_sum[c_ACC_LO +: ACC_W] = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
      assign w_sum[c_ACC_LO +: ACC_W] = w_old + r_s0_prod[c_ACC_LO +: ACC_W];
`endif
   end

   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         r_state   <= ST_IDLE;
         r_ready   <= 1'b0;
         r_elem    <= '0;
         r_line    <= '0;
         r_rd_ptr  <= '0;
         r_rd_done <= 1'b0;
      end else if (i_clear) begin
         r_state   <= ST_IDLE;
         r_ready   <= 1'b1;
         r_elem    <= '0;
         r_line    <= '0;
         r_rd_ptr  <= '0;
         r_rd_done <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_FIRST, ST_ACCUM: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  if (r_elem == c_LAST_ELEM) begin
                     r_elem <= '0;
                     if (r_line == c_LAST_LINE) begin
                        r_state <= ST_DRAIN;
                        r_ready <= 1'b0;
                        r_line  <= '0;
                     end else begin
                        r_state <= ST_ACCUM;
                        r_line  <= r_line + 1'b1;
                     end
                  end else begin
                     r_elem <= r_elem + 1'b1;
                     if (r_state == ST_IDLE) begin
                        r_state <= ST_FIRST;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               r_ready <= 1'b0;
               if (w_issue) begin
                  if (r_rd_ptr == c_LAST_ELEM) begin
                     r_rd_ptr  <= '0;
                     r_rd_done <= 1'b1;
                  end else begin
                     r_rd_ptr <= r_rd_ptr + 1'b1;
                  end
               end
               if (w_drain_done) begin
                  r_state   <= ST_IDLE;
                  r_ready   <= 1'b1;
                  r_rd_ptr  <= '0;
                  r_rd_done <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Read issued at the transfer edge; add next cycle; write the cycle after.
   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         r_s0_v     <= 1'b0;
         r_s0_first <= 1'b0;
         r_s0_addr  <= '0;
         r_s0_prod  <= '0;
         r_s1_v     <= 1'b0;
         r_s1_addr  <= '0;
         r_s1_data  <= '0;
      end else begin
         r_s0_v <= w_accept;
         if (w_accept) begin
            r_s0_addr  <= r_elem;
            r_s0_first <= (r_state != ST_ACCUM);
            r_s0_prod  <= w_prod;
         end
         r_s1_v <= r_s0_v && !i_clear;
         if (r_s0_v) begin
            r_s1_addr <= r_s0_addr;
            r_s1_data <= w_sum;
         end
      end
   end

   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         r_rd_v      <= 1'b0;
         r_rd_last   <= 1'b0;
         r_head      <= 1'b0;
         r_cnt       <= '0;
         r_fifo_last <= '0;
         for (int i = 0; i < c_FIFO_DEPTH; i++) begin
            r_fifo_data[i] <= '0;
         end
      end else if (i_clear) begin
         r_rd_v <= 1'b0;
         r_head <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_rd_v    <= w_issue;
         r_rd_last <= (r_rd_ptr == c_LAST_ELEM);
         if (w_push) begin
            r_fifo_data[w_wr_idx] <= w_ram_rdata;
            r_fifo_last[w_wr_idx] <= r_rd_last;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         r_cnt <= w_cnt_next;
      end
   end

`ifdef LINE_MAC_SAT_EN
   logic r_sat;

   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         r_sat <= 1'b0;
      end else if (i_clear || w_drain_done) begin
         r_sat <= 1'b0;
      end else if (r_s0_v && (|w_clamp)) begin
         r_sat <= 1'b1;
      end
   end

   assign o_sat = r_sat;
`endif

   assign o_ready = r_ready;
   assign o_valid = (r_cnt != 2'd0);
   assign o_data  = r_fifo_data[r_head];
   assign o_last  = o_valid && r_fifo_last[r_head];
   assign o_busy  = (r_state != ST_IDLE);

endmodule : line_mac_acc_pe
`default_nettype wire

// File: doc/line_mac_acc_pe.md
Name: line_mac_acc_pe

Overview:
- Parametrised spike-gated line accumulator for the attention × value path.
- Per element: each time step's attention score is masked by that step's value spike, then added into an on-chip line buffer at the element's index.
- Repeats over NUM_LINES consecutive lines; then streams the accumulated line out over a valid/ready handshake.
- Successor to the fixed 4-step/12-bit line MAC: adds parametrised width/depth, an internal RAM line buffer with explicit FSM, output backpressure, abort, and optional saturation.

Parameters:
- T_STEPS, 4, number of time steps (parallel lanes).
- IN_W, 5, attention score width per lane (unsigned).
- ACC_W, 12, accumulator width per lane (unsigned); must satisfy ACC_W > IN_W.
- LINE_LEN, 64, elements per line = line buffer depth; minimum 4.
- NUM_LINES, 64, lines accumulated before drain; minimum 1.

Ports:
- s_clk  in  1  clock.
- s_rst  in  1  reset, asynchronous, active-high.
- i_clear  in  1  synchronous abort; returns to IDLE and discards partial sums.
- i_valid  in  1  input element valid.
- o_ready  out  1  input accept.
- i_spikes  in  T_STEPS  value spikes, bit t gates lane t.
- i_attn  in  T_STEPS*IN_W  attention scores, lane t at [t*IN_W +: IN_W].
- o_valid  out  1  output element valid.
- i_ready  in  1  downstream accept.
- o_data  out  T_STEPS*ACC_W  accumulated lanes, lane t at [t*ACC_W +: ACC_W].
- o_last  out  1  marks the final element of the drained line.
- o_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: o_ready=0, o_valid=0, o_data=0, o_last=0, o_busy=0, elem_cnt=0, line_cnt=0, FSM=IDLE.
- Reset taken mid-operation discards all state; RAM contents are don't-care because the FIRST pass overwrites them.
- Transfer rules:
  - Input transfers when i_valid && o_ready.
  - Output transfers when o_valid && i_ready.
  - o_valid, once high, holds o_data/o_last stable until accepted.
- Per-lane product: p_t = i_spikes[t] ? i_attn_t : 0, zero-extended to ACC_W.
- FSM:
  - IDLE: o_ready=1. The first input transfer enters FIRST and is processed as element 0.
  - FIRST (line 0): writes p_t directly to RAM[elem_cnt], with no read.
  - ACCUM (lines 1..NUM_LINES-1): reads RAM[elem_cnt], adds p_t, writes the sum back.
  - After the last element of line NUM_LINES-1 → DRAIN. If NUM_LINES=1, go FIRST → DRAIN.
  - DRAIN: o_ready=0. Reads RAM[0..LINE_LEN-1] in order; o_last accompanies element LINE_LEN-1. Its acceptance → IDLE.
- Counters:
  - elem_cnt wraps at LINE_LEN-1 → 0; the wrap increments line_cnt.
  - Input gaps (i_valid=0) stall the counters; no timeout.
- Accumulate pipeline:
  - Stage 0: register inputs and issue the RAM read.
  - Stage 1: add.
  - Stage 2: write.
  - Write-back latency is 2 cycles after the transfer. A read of the same address recurs only after ≥LINE_LEN ≥4 transfers, so no bypass is needed.
- DRAIN timing:
  - RAM read latency 1, backed by a 2-entry skid register, so i_ready toggling causes no loss or duplication.
  - First o_valid appears ≤3 cycles after the final input write.
  - Sustained throughput is 1 element/cycle when i_ready=1.
- DRAIN waits for pipeline writes to retire before its first read.
- Arithmetic: without the option, sums wrap modulo 2^ACC_W.
- i_clear:
  - Highest priority; takes effect the next cycle in any state.
  - Drops in-flight pipeline writes, deasserts o_valid, zeroes the counters.
  - i_clear coinciding with an input transfer: that transfer is discarded.

Optional Feature:
- Macro LINE_MAC_SAT_EN.
- When defined: each lane add clamps at 2^ACC_W-1, and a sticky status output o_sat (1 bit, reset 0) is added. o_sat sets on any clamp and clears on IDLE entry or i_clear.
- When undefined: wrap-around arithmetic, and no o_sat port exists.

Decomposition:
- Shared package line_mac_pkg holds:
  - FSM state enum (IDLE, FIRST, ACCUM, DRAIN).
  - Lane slice helper constants.
  - Derived widths: CNT_W=$clog2(LINE_LEN), LCNT_W=$clog2(NUM_LINES+1).
- One sub-module, line_mac_ram: simple dual-port, registered-read, LINE_LEN × T_STEPS*ACC_W RAM, inferable as BRAM/LUTRAM.
- Add/saturate lanes are generated inline.

Test Plan (T_STEPS=4, IN_W=5, ACC_W=12, LINE_LEN=4, NUM_LINES=3 unless stated):
- All spikes=4'hF, attn lanes=31, 12 transfers back-to-back → 4 outputs, each lane=93; o_last on the 4th; o_busy drops 1 cycle after o_last accepted.
- Spikes=4'b0101, attn lanes=(10,20,30,31), 3 lines → lanes t0=30, t1=0, t2=90, t3=0 on every element.
- Drain with i_ready pattern 1,0,0,1,0,1,1 → exactly 4 elements in order 0..3, data stable while stalled, no duplicates.
- ACC_W=6, spikes=4'hF, attn=31, 3 lines:
  - without LINE_MAC_SAT_EN → lanes=(93 mod 64)=29;
  - with it → lanes=63 and o_sat=1.
- i_clear asserted after 6 input transfers, then a fresh 12-transfer run with attn=1 and spikes=4'hF → outputs=3 per lane; no residue from the aborted run.
- s_rst pulsed during DRAIN after 2 outputs → o_valid=0 immediately; FSM in IDLE; o_ready=1 on the first clock edge after reset release.
